// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} piso_state_t;

  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_if.sv
// Word-side valid/ready handshake into the serializer.
interface piso_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] d;
  logic             in_valid;
  logic             in_ready;

  modport master (output d, output in_valid, input in_ready);
  modport slave  (input d, input in_valid, output in_ready);
endinterface

// File: rtl/piso_tx_mod_counter.sv
// Synchronous up-counter with clear, enable and terminal-count flag; holds at MOD-1.
module mod_counter
  import piso_pkg::*;
#(
  parameter int MOD = 4,
  parameter int W   = cnt_w(MOD)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en && !tc)
      q <= q + 1'b1;
  end

  assign tc = (q == LAST);

endmodule

// File: rtl/piso_tx.sv
// Serializes one handshaked word per frame, one bit per clock, with optional idle gap.
//   state | meaning
//   IDLE  | waiting for a word, in_ready high
//   SHIFT | driving one data bit per cycle, sframe high
//   GAP   | GAP_CYCLES idle cycles between words
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1,
  parameter int LSB_FIRST  = 0
) (
  input  logic     clk,
  input  logic     reset,
  piso_if.slave    bus,
  output logic     sout,
  output logic     sframe,
  output logic     done,
  output logic     busy
);

  localparam int BW   = cnt_w(WIDTH);
  localparam int GW   = cnt_w(GAP_CYCLES + 1);
  localparam int GMOD = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;

  piso_state_t      state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             load, shift, ready;
  logic             bit_clr, bit_en, bit_tc;
  logic             gap_clr, gap_en, gap_tc;

  mod_counter #(.MOD(WIDTH), .W(BW)) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bit_clr),
    .en    (bit_en),
    .tc    (bit_tc)
  );

  mod_counter #(.MOD(GMOD), .W(GW)) u_gap_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (gap_clr),
    .en    (gap_en),
    .tc    (gap_tc)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Load wins over shift so a back-to-back word replaces the drained register.
  always_ff @(posedge clk) begin
    if (reset)
      shreg <= '0;
    else if (load)
      shreg <= bus.d;
    else if (shift)
      shreg <= (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    ready     = 1'b0;
    bit_clr   = 1'b0;
    bit_en    = 1'b0;
    gap_clr   = 1'b0;
    gap_en    = 1'b0;
    sframe    = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    sout      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          load      = 1'b1;
          bit_clr   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sframe = 1'b1;
        sout   = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];
        shift  = 1'b1;
        bit_en = 1'b1;
        if (bit_tc) begin
          done = 1'b1;
          if (GAP_CYCLES > 0) begin
            gap_clr   = 1'b1;
            state_nxt = GAP;
          end else begin
            ready = 1'b1;
            if (bus.in_valid) begin
              load    = 1'b1;
              bit_clr = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      GAP: begin
        gap_en = 1'b1;
        if (gap_tc)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready = ready;

endmodule
